// File: rtl/interp_seg_ctrl.sv
// Breakpoint-table sequencer for the linear interpolator: finds the segment
// enclosing x, drives its endpoints out, and returns y with a valid/ready handshake.
module interp_seg_ctrl #(
    parameter int unsigned W    = 10,
    parameter int unsigned NPTS = 8,
    parameter int unsigned AW   = 3,
    parameter int unsigned LAT  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_x,
    input  logic [W-1:0]  wr_y,
    output logic          wr_err,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [W-1:0]  req_x,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [W-1:0]  resp_y,
    output logic [W-1:0]  lin_x,
    output logic [W-1:0]  lin_x0,
    output logic [W-1:0]  lin_y0,
    output logic [W-1:0]  lin_x1,
    output logic [W-1:0]  lin_y1,
    input  logic [W-1:0]  lin_y
);
    // Table is sized to the full address space so any AW-bit index is legal;
    // entries at NPTS and above are never written and stay zero.
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [AW-1:0] LAST = AW'(NPTS - 1);
    localparam int unsigned CW = $clog2(LAT + 1) + 1;

    typedef enum logic [1:0] {IDLE, SEARCH, WAIT, DONE} state_t;

    state_t         state_reg;
    logic [W-1:0]   x_tab [DEPTH];
    logic [W-1:0]   y_tab [DEPTH];
    logic [W-1:0]   xq_reg;
    logic [AW-1:0]  idx_reg;
    logic           first_reg;
    logic [CW-1:0]  cnt_reg;
    logic [W-1:0]   resp_y_reg;
    logic           wr_err_reg;
    logic [W-1:0]   lin_x_reg, lin_x0_reg, lin_y0_reg, lin_x1_reg, lin_y1_reg;

    logic           wr_ok;
    logic [AW-1:0]  nxt_idx;

    // A request arriving in the same cycle takes priority over a table write.
    assign wr_ok   = wr_en && (state_reg == IDLE) && !req_valid && (32'(wr_addr) < NPTS);
    assign nxt_idx = idx_reg + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                x_tab[i] <= '0;
                y_tab[i] <= '0;
            end
        end else if (wr_ok) begin
            x_tab[wr_addr] <= wr_x;
            y_tab[wr_addr] <= wr_y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            xq_reg     <= '0;
            idx_reg    <= '0;
            first_reg  <= 1'b0;
            cnt_reg    <= '0;
            resp_y_reg <= '0;
            wr_err_reg <= 1'b0;
            lin_x_reg  <= '0;
            lin_x0_reg <= '0;
            lin_y0_reg <= '0;
            lin_x1_reg <= '0;
            lin_y1_reg <= '0;
        end else begin
            wr_err_reg <= wr_en && !wr_ok;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        xq_reg    <= req_x;
                        idx_reg   <= '0;
                        first_reg <= 1'b1;
                        state_reg <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (first_reg) begin
                        // Out-of-range queries clamp to the end values.
                        if (xq_reg <= x_tab[0]) begin
                            resp_y_reg <= y_tab[0];
                            state_reg  <= DONE;
                        end else if (xq_reg >= x_tab[LAST]) begin
                            resp_y_reg <= y_tab[LAST];
                            state_reg  <= DONE;
                        end
                        first_reg <= 1'b0;
                    end else if (xq_reg <= x_tab[nxt_idx]) begin
                        if (x_tab[idx_reg] == x_tab[nxt_idx]) begin
                            resp_y_reg <= y_tab[idx_reg];
                            state_reg  <= DONE;
                        end else begin
                            lin_x_reg  <= xq_reg;
                            lin_x0_reg <= x_tab[idx_reg];
                            lin_y0_reg <= y_tab[idx_reg];
                            lin_x1_reg <= x_tab[nxt_idx];
                            lin_y1_reg <= y_tab[nxt_idx];
                            cnt_reg    <= '0;
                            state_reg  <= WAIT;
                        end
                    end else begin
                        idx_reg <= nxt_idx;
                    end
                end
                WAIT: begin
                    if (cnt_reg == CW'(LAT)) begin
                        resp_y_reg <= lin_y;
                        state_reg  <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == DONE);
    assign resp_y     = resp_y_reg;
    assign wr_err     = wr_err_reg;
    assign lin_x      = lin_x_reg;
    assign lin_x0     = lin_x0_reg;
    assign lin_y0     = lin_y0_reg;
    assign lin_x1     = lin_x1_reg;
    assign lin_y1     = lin_y1_reg;

endmodule

// File: tb/tb_interp_seg_ctrl.sv
// Scoreboard bench for interp_seg_ctrl with a one-cycle reference interpolator;
// table x=(0,2,6,8), y=(0,4,6,7).
module tb_interp_seg_ctrl;
    localparam int W = 10;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_x, wr_y;
    logic          wr_err;
    logic          req_valid, req_ready;
    logic [W-1:0]  req_x;
    logic          resp_valid, resp_ready;
    logic [W-1:0]  resp_y;
    logic [W-1:0]  lin_x, lin_x0, lin_y0, lin_x1, lin_y1;
    logic [W-1:0]  lin_y = '0;

    interp_seg_ctrl #(.W(W), .NPTS(4), .AW(AW), .LAT(1)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y), .wr_err(wr_err),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_y(resp_y),
        .lin_x(lin_x), .lin_x0(lin_x0), .lin_y0(lin_y0), .lin_x1(lin_x1), .lin_y1(lin_y1),
        .lin_y(lin_y)
    );

    always #5 clk = ~clk;

    // Reference interpolator, one register stage.
    always @(posedge clk) begin
        if (lin_x1 == lin_x0)
            lin_y <= lin_y0;
        else
            lin_y <= W'(int'(lin_y0) + (int'(lin_x) - int'(lin_x0)) * (int'(lin_y1) - int'(lin_y0))
                        / (int'(lin_x1) - int'(lin_x0)));
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int x; int y; int lat;
        int lx; int lx0; int ly0; int lx1; int ly1;
        int e0;
    } exp_t;
    exp_t sb[$];
    exp_t cur;

    int nvec = 0;
    int nerr = 0;
    int ndone = 0;
    bit seen = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every response against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_resp: got resp_y=%0d, expected no response", resp_y);
            end else begin
                cur = sb[0];
                if (!seen) begin
                    chk("latency", cyc - cur.e0, cur.lat);
                    chk("lin_x", int'(lin_x), cur.lx);
                    chk("lin_x0", int'(lin_x0), cur.lx0);
                    chk("lin_y0", int'(lin_y0), cur.ly0);
                    chk("lin_x1", int'(lin_x1), cur.lx1);
                    chk("lin_y1", int'(lin_y1), cur.ly1);
                    seen = 1'b1;
                end
                chk("resp_y", int'(resp_y), cur.y);
                if (!resp_ready) chk("req_ready_stall", int'(req_ready), 0);
                if (resp_ready) begin
                    $display("txn x=%0d y=%0d lat=%0d", cur.x, resp_y, cyc - cur.e0);
                    void'(sb.pop_front());
                    seen = 1'b0;
                    ndone++;
                end
            end
        end
    end

    // All stimulus tasks start and end #1 after a rising edge.
    task automatic wr(input int a, input int x, input int y, input int exp_err);
        wr_en = 1'b1; wr_addr = AW'(a); wr_x = W'(x); wr_y = W'(y);
        @(posedge clk); #1;
        wr_en = 1'b0;
        chk("wr_err", int'(wr_err), exp_err);
        @(posedge clk); #1;
        chk("wr_err_pulse", int'(wr_err), 0);
    endtask

    task automatic send(input int x, input bit push, input int y, input int lat,
                        input int lx, input int lx0, input int ly0, input int lx1, input int ly1);
        exp_t e;
        req_valid = 1'b1; req_x = W'(x);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (push) begin
            e.x = x; e.y = y; e.lat = lat;
            e.lx = lx; e.lx0 = lx0; e.ly0 = ly0; e.lx1 = lx1; e.ly1 = ly1;
            e.e0 = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        int start;
        start = ndone;
        for (int t = 0; t < 60 && ndone == start; t++) @(posedge clk);
        if (ndone == start) chk("resp_timeout", 0, 1);
        #1;
    endtask

    task automatic txn(input int x, input int y, input int lat,
                       input int lx, input int lx0, input int ly0, input int lx1, input int ly1);
        send(x, 1'b1, y, lat, lx, lx0, ly0, lx1, ly1);
        wait_done();
    endtask

    task automatic load_table();
        wr(0, 0, 0, 0);
        wr(1, 2, 4, 0);
        wr(2, 6, 6, 0);
        wr(3, 8, 7, 0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_y = '0;
        req_valid = 1'b0; req_x = '0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_resp_y", int'(resp_y), 0);
        chk("rst_wr_err", int'(wr_err), 0);
        chk("rst_lin", int'(lin_x | lin_x0 | lin_y0 | lin_x1 | lin_y1), 0);

        load_table();
        wr(5, 1, 1, 1);
        chk("idle_req_ready", int'(req_ready), 1);

        // Interpolated segments.
        txn(4, 5, 5, 4, 2, 4, 6, 6);
        txn(7, 6, 6, 7, 6, 6, 8, 7);
        txn(2, 4, 4, 2, 0, 0, 2, 4);
        txn(6, 6, 5, 6, 2, 4, 6, 6);

        // Clamps leave lin_* untouched.
        txn(9, 7, 1, 6, 2, 4, 6, 6);
        txn(0, 0, 1, 6, 2, 4, 6, 6);
        txn(8, 7, 1, 6, 2, 4, 6, 6);

        // Backpressure: hold the result for 5 cycles.
        resp_ready = 1'b0;
        send(4, 1'b1, 5, 5, 4, 2, 4, 6, 6);
        for (int t = 0; t < 40 && !resp_valid; t++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        resp_ready = 1'b1;
        wait_done();

        // Write while searching is rejected.
        send(7, 1'b1, 6, 6, 7, 6, 6, 8, 7);
        wr_en = 1'b1; wr_addr = 3'd2; wr_x = 10'd1; wr_y = 10'd1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        chk("wr_err_busy", int'(wr_err), 1);
        wait_done();
        txn(7, 6, 6, 7, 6, 6, 8, 7);

        // Write colliding with a request in IDLE loses.
        wr_en = 1'b1; wr_addr = 3'd3; wr_x = 10'd1; wr_y = 10'd1;
        send(9, 1'b1, 7, 1, 7, 6, 6, 8, 7);
        wr_en = 1'b0;
        chk("wr_err_collide", int'(wr_err), 1);
        wait_done();
        txn(8, 7, 1, 7, 6, 6, 8, 7);

        // Repeated breakpoint x=(0,2,2,8).
        wr(2, 2, 6, 0);
        txn(2, 4, 4, 2, 0, 0, 2, 4);
        txn(5, 6, 6, 5, 2, 6, 8, 7);
        wr(2, 6, 6, 0);

        // Reset during WAIT aborts the request.
        send(7, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_in_wait_lin_x", int'(lin_x), 7);
        rst = 1'b1;
        #1;
        chk("abort_req_ready", int'(req_ready), 1);
        chk("abort_resp_valid", int'(resp_valid), 0);
        chk("abort_lin_x", int'(lin_x), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        load_table();
        txn(4, 5, 5, 4, 2, 4, 6, 6);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
